// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel arbiter.
package dma_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    localparam int CMD_DISABLE   = 2;
    localparam int CMD_ROTATE    = 4;
    localparam int CMD_DREQ_LOW  = 6;
    localparam int CMD_DACK_HIGH = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arbState_t;

    function automatic logic [NUM_CH-1:0] chOneHot(input logic [CH_W-1:0] ch);
        chOneHot = {{(NUM_CH-1){1'b0}}, 1'b1} << ch;
    endfunction

endpackage

// File: rtl/dma_prio_pick.sv
// Combinational channel picker: fixed (ch0 highest) or rotating from ptr.
module dma_prio_pick
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0] eff,
    input  logic [CH_W-1:0]   ptr,
    input  logic              rotate,
    output logic              any,
    output logic [CH_W-1:0]   winner
);

    logic [CH_W-1:0] base_s;
    logic [CH_W-1:0] idx_s;

    // Walk from lowest to highest priority so the highest requester is written last
    always_comb begin
        any    = |eff;
        winner = {CH_W{1'b0}};
        idx_s  = {CH_W{1'b0}};
        if (rotate) begin
            base_s = ptr;
        end else begin
            base_s = {CH_W{1'b0}};
        end
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx_s  = base_s + CH_W'(k);
            winner = eff[idx_s] ? idx_s : winner;
        end
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: DREQ synchroniser, HRQ/HLDA bus-hold FSM, rotate pointer
// and DACK/grant outputs for the timing FSM.
module dma_channel_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        commandReg,
    input  logic [7:0]        requestReg,
    input  logic [7:0]        maskReg,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic              grantValid,
    output logic [1:0]        grantCh,
    output logic [NUM_CH-1:0] DACK,
    output logic [NUM_CH-1:0] swReqClr
);

    import dma_pkg::*;

    logic [NUM_CH-1:0] syncChain_r [SYNC_STAGES];
    logic [NUM_CH-1:0] dreq_s;
    logic [NUM_CH-1:0] eff_s;
    logic              any_s;
    logic [1:0]        winner_s;

    arbState_t         state_r, stateNext_s;
    logic              hrq_r, hrqNext_s;
    logic              grantValid_r, grantValidNext_s;
    logic [1:0]        grantCh_r, grantChNext_s;
    logic [NUM_CH-1:0] ack_r, ackNext_s;
    logic [1:0]        ptr_r, ptrNext_s;
    logic [NUM_CH-1:0] swReqClr_s;
    logic              serviceOk_s;
    logic              grantLoad_s;
    logic              unusedBits_s;

    assign unusedBits_s = ^{commandReg[5], commandReg[3], commandReg[1:0],
                            requestReg[7:NUM_CH], maskReg[7:NUM_CH]};

    // Flop chain bringing asynchronous DREQ into the clock domain
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncChain_r[i] <= {NUM_CH{1'b0}};
            end
        end else begin
            syncChain_r[0] <= DREQ;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncChain_r[i] <= syncChain_r[i-1];
            end
        end
    end

    assign dreq_s = syncChain_r[SYNC_STAGES-1];
    // Software requests bypass the mask; hardware requests are normalised to active-high first
    assign eff_s  = ((dreq_s ^ {NUM_CH{commandReg[CMD_DREQ_LOW]}}) & ~maskReg[NUM_CH-1:0])
                  | requestReg[NUM_CH-1:0];

    dma_prio_pick u_pick (
        .eff    (eff_s),
        .ptr    (ptr_r),
        .rotate (commandReg[CMD_ROTATE]),
        .any    (any_s),
        .winner (winner_s)
    );

    assign serviceOk_s = (state_r == GRANT) && HLDA && serviceDone;
    assign grantLoad_s = (state_r == REQ) && HLDA && any_s;

    // State register plus registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= IDLE;
            hrq_r        <= 1'b0;
            grantValid_r <= 1'b0;
            grantCh_r    <= 2'd0;
            ack_r        <= {NUM_CH{1'b0}};
            ptr_r        <= 2'd0;
        end else begin
            state_r      <= stateNext_s;
            hrq_r        <= hrqNext_s;
            grantValid_r <= grantValidNext_s;
            grantCh_r    <= grantChNext_s;
            ack_r        <= ackNext_s;
            ptr_r        <= ptrNext_s;
        end
    end

    // Next-state logic; losing HLDA in GRANT takes precedence over serviceDone
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (!commandReg[CMD_DISABLE] && any_s) begin
                    stateNext_s = REQ;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            REQ: begin
                if (!any_s) begin
                    stateNext_s = IDLE;
                end else if (HLDA) begin
                    stateNext_s = GRANT;
                end else if (commandReg[CMD_DISABLE]) begin
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = REQ;
                end
            end
            GRANT: begin
                if (!HLDA || serviceDone) begin
                    stateNext_s = RELEASE;
                end else begin
                    stateNext_s = GRANT;
                end
            end
            RELEASE: stateNext_s = IDLE;
            default: stateNext_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so HRQ/DACK change with the state itself
    always_comb begin
        hrqNext_s        = (stateNext_s == REQ) || (stateNext_s == GRANT);
        grantValidNext_s = (stateNext_s == GRANT);
        if (grantLoad_s) begin
            grantChNext_s = winner_s;
        end else begin
            grantChNext_s = grantCh_r;
        end
        if (grantValidNext_s) begin
            ackNext_s = chOneHot(grantChNext_s);
        end else begin
            ackNext_s = {NUM_CH{1'b0}};
        end
        if (serviceOk_s && commandReg[CMD_ROTATE]) begin
            ptrNext_s = grantCh_r + 2'd1;
        end else begin
            ptrNext_s = ptr_r;
        end
        if (serviceOk_s) begin
            swReqClr_s = chOneHot(grantCh_r) & requestReg[NUM_CH-1:0];
        end else begin
            swReqClr_s = {NUM_CH{1'b0}};
        end
    end

    // DACK polarity follows commandReg immediately, independent of the register
    always_comb begin
        if (commandReg[CMD_DACK_HIGH]) begin
            DACK = ack_r;
        end else begin
            DACK = ~ack_r;
        end
    end

    assign HRQ        = hrq_r;
    assign grantValid = grantValid_r;
    assign grantCh    = grantCh_r;
    assign swReqClr   = swReqClr_s;

endmodule
